delay_line_ctrl: RTL
====================

# delay_line_ctrl

Echo/delay engine that uses the 16K x 16 dual-port audio SRAM as a circular sample buffer. Each accepted input sample produces one read of the delayed sample on SRAM port 1 (read-only). The sample is then mixed with the delayed value and written back, with feedback, on SRAM port 0 (RW). The block sits directly upstream of the SRAM, between the audio sample pipeline and the memory, and emits the mixed output sample downstream.

## Interface
- ADDR_WIDTH, 14: SRAM address width; buffer depth 2^ADDR_WIDTH words.
- DATA_WIDTH, 16: signed two's-complement sample width.
- GAIN_WIDTH, 8: unsigned Q0.8 gain width.
- clk  in  1  single clock; SRAM clk0/clk1 are tied to this same net at top level.
- rst_n  in  1  asynchronous, active-low reset.
- sample_valid  in  1  one-cycle strobe: sample_in is valid.
- sample_in  in  16  signed input sample.
- sample_ready  out  1  high when a sample can be accepted (IDLE and init_done).
- delay_len  in  14  delay in samples, latched on accept; 0 disables the delayed term.
- fb_gain  in  8  feedback gain, Q0.8.
- mix_gain  in  8  wet mix gain, Q0.8.
- out_valid  out  1  one-cycle strobe: sample_out is valid.
- sample_out  out  16  signed mixed output sample.
- overrun  out  1  sticky flag: a sample arrived while busy.
- overrun_clr  in  1  synchronous clear of overrun.
- init_done  out  1  high once buffer zeroing is complete.
- sram_csb0, sram_web0  out  1 each  port-0 chip select and write enable, both active low.
- sram_addr0  out  14  port-0 address.
- sram_din0  out  16  port-0 write data.
- sram_csb1  out  1  port-1 chip select, active low.
- sram_addr1  out  14  port-1 address.
- sram_dout1  in  16  port-1 read data.

## Operation
- Reset values:
  - csb0, web0 and csb1 = 1.
  - addr0, addr1, din0 = 0.
  - sample_out = 0, out_valid = 0, overrun = 0, init_done = 0, sample_ready = 0.
  - wr_ptr = 0; state = INIT.
- INIT:
  - Writes 0 to addresses 0..16383 via port 0, one word per cycle (csb0 = 0, web0 = 0).
  - After address 16383 the block sets init_done = 1, deasserts csb0 and web0, and moves to IDLE.
  - sample_valid is ignored during INIT; overrun is not set.
- IDLE: on sample_valid, the block:
  - latches x = sample_in, D = delay_len, fb_gain and mix_gain;
  - drives csb1 = 0 and addr1 = (wr_ptr − D) mod 2^14;
  - moves to RD.
- RD: SRAM captures addr1 at this edge. The block drives csb1 = 1 and moves to WT.
- WT: the block registers d = sram_dout1, or d = 0 if D = 0, then moves to MAC.
- MAC:
  - fb = sat16(x + ((d × fb_gain) >>> 8)).
  - y = sat16(x + ((d × mix_gain) >>> 8)).
  - Products are 24-bit signed; the shift is arithmetic (floor); sums are 17-bit, saturated to [−32768, 32767].
  - Drives csb0 = 0, web0 = 0, addr0 = wr_ptr, din0 = fb.
  - Registers sample_out = y; moves to WR.
- WR:
  - csb0 = 1, web0 = 1; out_valid = 1 for exactly one cycle.
  - wr_ptr increments, wrapping from 16383 to 0.
  - Returns to IDLE.
- Overrun:
  - sample_valid while init_done = 1 and state ≠ IDLE sets overrun; that sample is dropped.
  - overrun_clr clears the flag; if overrun_clr and a new overrun occur in the same cycle, set wins.
- Ports 0 and 1 never address the same word in the same cycle, because read and write occur in different states.
- Reset mid-operation: all in-flight work is aborted, all outputs return to reset values, and INIT restarts from address 0.

## Timing
- Accept at edge E0:
  - addr1 is presented at E0 and captured by the SRAM at E1.
  - dout1 is valid after negedge E1 and registered at E2.
  - The write is presented at E3 and captured by the SRAM at E4, with the memory write at negedge E4.
  - out_valid and sample_out are valid in the cycle following E4.
- Minimum accept spacing is 5 cycles. sample_ready falls the cycle after an accept and rises again after the WR cycle.
- INIT lasts 16384 cycles after rst_n deasserts; init_done rises on the next edge.
- sample_out holds its value between out_valid strobes.

## Test plan
- Init: release reset → exactly 16384 port-0 writes of 0 to addresses 0..16383, in order; init_done = 1 after the last; sample_valid during INIT produces no out_valid.
- Impulse:
  - Setup: D = 4, fb_gain = 0, mix_gain = 128; send 1000 then 0,0,0,0,0.
  - Required sample_out sequence: 1000, 0, 0, 0, 500, 0.
  - Port-0 din equals the inputs.
- Feedback:
  - Setup: D = 1, fb_gain = 128, mix_gain = 255; send 4096 then zeros.
  - Stored words: 4096, 2048, 1024, ….
  - Outputs: 4096, 4080, 2040, ….
  - Floor on negatives: d = −3, gain 128 gives −2.
- Saturation:
  - x = 30000, d = 20000, mix_gain = 255 → sample_out = 32767.
  - x = −30000, d = −20000 → sample_out = −32768.
- Wrap: with wr_ptr = 16382 and D = 16383 → addr1 = 16383; wr_ptr sequence is 16382, 16383, 0, 1.
- Overrun/reset: sample_valid 2 cycles after an accept → overrun = 1 and only one out_valid; overrun_clr → 0; rst_n pulse during MAC → no write, no out_valid, INIT restarts.

Source files
------------

// File: rtl/delay_line_ctrl.sv
// delay_line_ctrl: circular-buffer echo engine on a 16K x 16 dual-port SRAM.
// Port 1 reads the delayed sample, port 0 writes the mixed feedback sample.
`default_nettype none

module delay_line_ctrl #(
  parameter int ADDR_WIDTH = 14,
  parameter int DATA_WIDTH = 16,
  parameter int GAIN_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  sample_valid,
  input  logic [DATA_WIDTH-1:0] sample_in,
  output logic                  sample_ready,
  input  logic [ADDR_WIDTH-1:0] delay_len,
  input  logic [GAIN_WIDTH-1:0] fb_gain,
  input  logic [GAIN_WIDTH-1:0] mix_gain,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] sample_out,
  output logic                  overrun,
  input  logic                  overrun_clr,
  output logic                  init_done,
  output logic                  sram_csb0,
  output logic                  sram_web0,
  output logic [ADDR_WIDTH-1:0] sram_addr0,
  output logic [DATA_WIDTH-1:0] sram_din0,
  output logic                  sram_csb1,
  output logic [ADDR_WIDTH-1:0] sram_addr1,
  input  logic [DATA_WIDTH-1:0] sram_dout1
);

  localparam int PW = DATA_WIDTH + GAIN_WIDTH + 1;
  localparam int SW = DATA_WIDTH + 2;

  typedef enum logic [2:0] {
    S_INIT = 3'd0,
    S_IDLE = 3'd1,
    S_RD   = 3'd2,
    S_WT   = 3'd3,
    S_MAC  = 3'd4,
    S_WR   = 3'd5
  } state_t;

  state_t                state_q;
  logic [ADDR_WIDTH-1:0] wr_ptr_q;
  logic [DATA_WIDTH-1:0] x_q;
  logic [ADDR_WIDTH-1:0] dlen_q;
  logic [GAIN_WIDTH-1:0] fbg_q;
  logic [GAIN_WIDTH-1:0] mixg_q;
  logic [DATA_WIDTH-1:0] d_q;
  logic                  ready_q;
  logic                  out_valid_q;
  logic [DATA_WIDTH-1:0] sample_out_q;
  logic                  overrun_q;
  logic                  init_done_q;
  logic                  csb0_q;
  logic                  web0_q;
  logic [ADDR_WIDTH-1:0] addr0_q;
  logic [DATA_WIDTH-1:0] din0_q;
  logic                  csb1_q;
  logic [ADDR_WIDTH-1:0] addr1_q;

  logic [PW-1:0]         fb_prod;
  logic [PW-1:0]         mix_prod;
  logic [SW-1:0]         fb_sum;
  logic [SW-1:0]         mix_sum;
  logic [DATA_WIDTH-1:0] fb_d;
  logic [DATA_WIDTH-1:0] y_d;

  function automatic logic [DATA_WIDTH-1:0] sat(input logic [SW-1:0] s);
    logic [DATA_WIDTH-1:0] r;
    if (s[SW-1:DATA_WIDTH-1] == '0 || s[SW-1:DATA_WIDTH-1] == '1) begin
      r = s[DATA_WIDTH-1:0];
    end else if (s[SW-1]) begin
      r = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    end else begin
      r = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    end
    return r;
  endfunction

  // Signed sample times unsigned Q0.8 gain; >>> on the product gives floor division.
  always_comb begin
    fb_prod  = $signed({{(GAIN_WIDTH+1){d_q[DATA_WIDTH-1]}}, d_q})
             * $signed({{(DATA_WIDTH+1){1'b0}}, fbg_q});
    mix_prod = $signed({{(GAIN_WIDTH+1){d_q[DATA_WIDTH-1]}}, d_q})
             * $signed({{(DATA_WIDTH+1){1'b0}}, mixg_q});
    fb_sum   = {{2{x_q[DATA_WIDTH-1]}}, x_q}
             + {fb_prod[PW-1], fb_prod[PW-1:GAIN_WIDTH]};
    mix_sum  = {{2{x_q[DATA_WIDTH-1]}}, x_q}
             + {mix_prod[PW-1], mix_prod[PW-1:GAIN_WIDTH]};
    fb_d     = sat(fb_sum);
    y_d      = sat(mix_sum);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_INIT;
      wr_ptr_q     <= '0;
      x_q          <= '0;
      dlen_q       <= '0;
      fbg_q        <= '0;
      mixg_q       <= '0;
      d_q          <= '0;
      ready_q      <= 1'b0;
      out_valid_q  <= 1'b0;
      sample_out_q <= '0;
      overrun_q    <= 1'b0;
      init_done_q  <= 1'b0;
      csb0_q       <= 1'b1;
      web0_q       <= 1'b1;
      addr0_q      <= '0;
      din0_q       <= '0;
      csb1_q       <= 1'b1;
      addr1_q      <= '0;
    end else begin
      out_valid_q <= 1'b0;
      if (sample_valid && init_done_q && state_q != S_IDLE) begin
        overrun_q <= 1'b1;
      end else if (overrun_clr) begin
        overrun_q <= 1'b0;
      end

      case (state_q)
        // First edge opens the write at address 0; each later edge advances one word.
        S_INIT: begin
          if (csb0_q) begin
            csb0_q  <= 1'b0;
            web0_q  <= 1'b0;
            addr0_q <= '0;
            din0_q  <= '0;
          end else if (addr0_q == '1) begin
            csb0_q      <= 1'b1;
            web0_q      <= 1'b1;
            init_done_q <= 1'b1;
            ready_q     <= 1'b1;
            state_q     <= S_IDLE;
          end else begin
            addr0_q <= addr0_q + ADDR_WIDTH'(1);
          end
        end
        S_IDLE: begin
          if (sample_valid) begin
            x_q     <= sample_in;
            dlen_q  <= delay_len;
            fbg_q   <= fb_gain;
            mixg_q  <= mix_gain;
            csb1_q  <= 1'b0;
            addr1_q <= wr_ptr_q - delay_len;
            ready_q <= 1'b0;
            state_q <= S_RD;
          end
        end
        S_RD: begin
          csb1_q  <= 1'b1;
          state_q <= S_WT;
        end
        S_WT: begin
          d_q     <= (dlen_q == '0) ? '0 : sram_dout1;
          state_q <= S_MAC;
        end
        S_MAC: begin
          csb0_q       <= 1'b0;
          web0_q       <= 1'b0;
          addr0_q      <= wr_ptr_q;
          din0_q       <= fb_d;
          sample_out_q <= y_d;
          state_q      <= S_WR;
        end
        S_WR: begin
          csb0_q      <= 1'b1;
          web0_q      <= 1'b1;
          out_valid_q <= 1'b1;
          wr_ptr_q    <= wr_ptr_q + ADDR_WIDTH'(1);
          ready_q     <= 1'b1;
          state_q     <= S_IDLE;
        end
        default: state_q <= S_INIT;
      endcase
    end
  end

  assign sample_ready = ready_q;
  assign out_valid    = out_valid_q;
  assign sample_out   = sample_out_q;
  assign overrun      = overrun_q;
  assign init_done    = init_done_q;
  assign sram_csb0    = csb0_q;
  assign sram_web0    = web0_q;
  assign sram_addr0   = addr0_q;
  assign sram_din0    = din0_q;
  assign sram_csb1    = csb1_q;
  assign sram_addr1   = addr1_q;

endmodule

`default_nettype wire
